ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline register between the execute stage (ALU output) and the memory stage of the 5-stage RV32I core. It captures the ALU result, flags, store data and control bits once per cycle, with stall (hold) and flush (bubble) support. It also prepares store byte enables, lane-replicated store data and misalignment flags for the data memory, and drives the forwarding value back to execute.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_m  in  1  hold all registers
- flush_m  in  1  insert bubble
- valid_e  in  1  EX holds a real instruction
- aluresult_e  in  32  ALU result; also the memory address
- flags_e  in  4  ALU flags {o,c,n,z}
- writedata_e  in  32  rs2 value for stores
- pcplus4_e  in  32  PC+4 for JAL/JALR writeback
- rd_e  in  5  destination register
- regwrite_e, memwrite_e, memread_e  in  1 each  control bits
- resultsrc_e  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- funct3_e  in  3  load/store size and sign
- valid_m  out  1  MEM holds a real instruction
- aluresult_m, pcplus4_m  out  32  registered copies
- flags_m  out  4  registered flags
- rd_m  out  5; regwrite_m, memread_m  out  1; resultsrc_m  out  2; funct3_m  out  3
- memwrite_m  out  1  store strobe, already qualified by alignment
- byteen_m  out  4  store byte enables
- wdata_m  out  32  lane-replicated store data
- misalign_m  out  1  misaligned load or store captured
- fwd_m  out  32  forwarding value: pcplus4_m if resultsrc_m==10, else aluresult_m

## Operation
- Register update priority on each rising edge: reset > flush_m > stall_m > load.
- Reset or flush: every output register is set to 0. This includes valid_m, control bits, data fields, byteen_m and misalign_m.
- Stall without flush: every register holds its value.
- Load: all *_e fields are captured. valid_m <= valid_e. If valid_e is 0, the control bits regwrite, memwrite and memread are captured as 0.
- Store preparation is computed from funct3_e and addr = aluresult_e[1:0], and is registered on load:
  - SB (000): byteen = 0001 << addr; wdata = {4{wd[7:0]}}
  - SH (001): byteen = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}; misaligned if addr[0]
  - SW (010): byteen = 1111; wdata = wd; misaligned if addr != 00
  - Any other funct3 on a store: byteen = 0000, memwrite captured as 0, not flagged as misaligned.
- Load misalignment: LH/LHU (001/101) are misaligned if addr[0]; LW (010) is misaligned if addr != 00. LB/LBU are never misaligned.
- Misaligned store: memwrite_m = 0, byteen_m = 0000, misalign_m = 1. rd_m and regwrite_m are captured unchanged.
- Misaligned load: memread_m captured as 1 and misalign_m = 1. Trap handling happens downstream.
- When not storing (memwrite_e = 0): byteen_m = 0000, but wdata_m is still the replicated data.
- fwd_m is combinational from the registered outputs only. There is no path from *_e inputs to any output.

## Timing
- Latency is 1 cycle: a value presented on *_e in cycle N appears on *_m in cycle N+1.
- All outputs are 0 in the first cycle after reset is sampled high.
- flush_m and stall_m asserted together: flush wins, and a bubble is inserted.
- A stall can last any number of cycles. Outputs stay bit-identical for the whole stall and update on the first edge where stall_m is 0.
- Reset asserted mid-stall clears everything on that edge.

## Test plan
- Reset: hold reset for 2 cycles with nonzero inputs -> all outputs 0 and fwd_m = 0.
- SB: store with aluresult_e = 0x1003, writedata_e = 0x123456AB, funct3 000 -> next cycle byteen_m = 1000, wdata_m = 0xABABABAB, memwrite_m = 1, misalign_m = 0.
- Misaligned SW: aluresult_e = 0x1002, funct3 010, memwrite_e = 1 -> memwrite_m = 0, byteen_m = 0000, misalign_m = 1. Also LH at 0x1001 -> memread_m = 1, misalign_m = 1.
- Stall: load a result of 0xDEADBEEF, then assert stall_m for 3 cycles while inputs change -> outputs hold 0xDEADBEEF each cycle and take the new input on release.
- Flush priority: stall_m = 1 and flush_m = 1 together with regwrite_m = 1 -> next cycle valid_m = 0, regwrite_m = 0, aluresult_m = 0.
- Forwarding: resultsrc_e = 10, pcplus4_e = 0x104, aluresult_e = 0x55 -> fwd_m = 0x104. With resultsrc_e = 00 -> fwd_m = 0x55.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the RV32I core: captures execute results, prepares
// store byte enables / lane-replicated data / misalignment flags, and feeds forwarding.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_m,
  input  logic            flush_m,
  input  logic            valid_e,
  input  logic [XLEN-1:0] aluresult_e,
  input  logic [3:0]      flags_e,
  input  logic [XLEN-1:0] writedata_e,
  input  logic [XLEN-1:0] pcplus4_e,
  input  logic [4:0]      rd_e,
  input  logic            regwrite_e,
  input  logic            memwrite_e,
  input  logic            memread_e,
  input  logic [1:0]      resultsrc_e,
  input  logic [2:0]      funct3_e,
  output logic            valid_m,
  output logic [XLEN-1:0] aluresult_m,
  output logic [XLEN-1:0] pcplus4_m,
  output logic [3:0]      flags_m,
  output logic [4:0]      rd_m,
  output logic            regwrite_m,
  output logic            memread_m,
  output logic [1:0]      resultsrc_m,
  output logic [2:0]      funct3_m,
  output logic            memwrite_m,
  output logic [3:0]      byteen_m,
  output logic [XLEN-1:0] wdata_m,
  output logic            misalign_m,
  output logic [XLEN-1:0] fwd_m
);

  // Pipeline control: reset > flush_m (bubble) > stall_m (hold) > load.
  logic [1:0]      addr;
  logic            is_store, is_load;
  logic            st_legal, st_mis, ld_mis, st_ok;
  logic [3:0]      byteen_n;
  logic [XLEN-1:0] wdata_n;

  assign addr = aluresult_e[1:0];

  always_comb begin
    is_store = valid_e & memwrite_e;
    is_load  = valid_e & memread_e;
    st_legal = 1'b0;
    st_mis   = 1'b0;
    ld_mis   = 1'b0;
    byteen_n = 4'b0000;
    wdata_n  = writedata_e;
    case (funct3_e)
      3'b000: begin
        st_legal = 1'b1;
        byteen_n = 4'b0001 << addr;
        wdata_n  = {4{writedata_e[7:0]}};
      end
      3'b001: begin
        st_legal = 1'b1;
        st_mis   = addr[0];
        ld_mis   = addr[0];
        byteen_n = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n  = {2{writedata_e[15:0]}};
      end
      3'b010: begin
        st_legal = 1'b1;
        st_mis   = (addr != 2'b00);
        ld_mis   = (addr != 2'b00);
        byteen_n = 4'b1111;
      end
      3'b101: ld_mis = addr[0];
      default: ;
    endcase
    // Only a legal, aligned store reaches memory; everything else is squashed here.
    st_ok = is_store & st_legal & ~st_mis;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_m) begin
      valid_m     <= 1'b0;
      aluresult_m <= '0;
      pcplus4_m   <= '0;
      flags_m     <= 4'b0000;
      rd_m        <= 5'd0;
      regwrite_m  <= 1'b0;
      memread_m   <= 1'b0;
      resultsrc_m <= 2'b00;
      funct3_m    <= 3'b000;
      memwrite_m  <= 1'b0;
      byteen_m    <= 4'b0000;
      wdata_m     <= '0;
      misalign_m  <= 1'b0;
    end else if (!stall_m) begin
      valid_m     <= valid_e;
      aluresult_m <= aluresult_e;
      pcplus4_m   <= pcplus4_e;
      flags_m     <= flags_e;
      rd_m        <= rd_e;
      regwrite_m  <= valid_e & regwrite_e;
      memread_m   <= is_load;
      resultsrc_m <= resultsrc_e;
      funct3_m    <= funct3_e;
      memwrite_m  <= st_ok;
      byteen_m    <= st_ok ? byteen_n : 4'b0000;
      wdata_m     <= wdata_n;
      misalign_m  <= (is_store & st_legal & st_mis) | (is_load & ld_mis);
    end
  end

  assign fwd_m = (resultsrc_m == 2'b10) ? pcplus4_m : aluresult_m;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed table of spec scenarios, then random traffic
// checked against a per-cycle reference model of the pipeline register.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [3:0]  flags;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw, mw, mr;
    logic [1:0]  rs;
    logic [2:0]  f3;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic        mw;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mis;
    logic [31:0] fwd;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct {
    string       name;
    logic        r, st, fl;
    in_t         i;
    logic        ev, erw, emw, emr, emis;
    logic [3:0]  ebe;
    logic [31:0] ealu, ewd, efwd;
  } vec_t;

  logic clk = 1'b0;
  logic reset, stall_m, flush_m;
  logic valid_e, regwrite_e, memwrite_e, memread_e;
  logic [31:0] aluresult_e, writedata_e, pcplus4_e;
  logic [3:0]  flags_e;
  logic [4:0]  rd_e;
  logic [1:0]  resultsrc_e;
  logic [2:0]  funct3_e;
  logic        valid_m, regwrite_m, memread_m, memwrite_m, misalign_m;
  logic [31:0] aluresult_m, pcplus4_m, wdata_m, fwd_m;
  logic [3:0]  flags_m, byteen_m;
  logic [4:0]  rd_m;
  logic [1:0]  resultsrc_m;
  logic [2:0]  funct3_m;

  ex_mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall_m(stall_m), .flush_m(flush_m),
    .valid_e(valid_e), .aluresult_e(aluresult_e), .flags_e(flags_e),
    .writedata_e(writedata_e), .pcplus4_e(pcplus4_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .memread_e(memread_e),
    .resultsrc_e(resultsrc_e), .funct3_e(funct3_e),
    .valid_m(valid_m), .aluresult_m(aluresult_m), .pcplus4_m(pcplus4_m),
    .flags_m(flags_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .memread_m(memread_m), .resultsrc_m(resultsrc_m), .funct3_m(funct3_m),
    .memwrite_m(memwrite_m), .byteen_m(byteen_m), .wdata_m(wdata_m),
    .misalign_m(misalign_m), .fwd_m(fwd_m)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] exp_q[$];
  out_t exp_state = '0;
  out_t act;
  vec_t tbl[$];

  // Reference model: what a single load captures, derived from access size rules.
  function automatic out_t model_load(input in_t i);
    out_t o;
    int a, st_size, ld_size;
    logic store, load, legal, st_mis, ld_mis, do_st;
    o = '0;
    a = int'(i.alu[1:0]);
    store = i.valid && i.mw;
    load  = i.valid && i.mr;
    legal = (i.f3 <= 3'd2);
    st_size = (i.f3 == 3'd0) ? 1 : (i.f3 == 3'd1) ? 2 : 4;
    if (i.f3 == 3'd1 || i.f3 == 3'd5) ld_size = 2;
    else if (i.f3 == 3'd2) ld_size = 4;
    else ld_size = 1;
    st_mis = store && legal && (a % st_size != 0);
    ld_mis = load && (a % ld_size != 0);
    do_st  = store && legal && !st_mis;
    o.valid = i.valid;
    o.alu = i.alu;
    o.pc = i.pc;
    o.flags = i.flags;
    o.rd = i.rd;
    o.rw = i.valid && i.rw;
    o.mr = load;
    o.rs = i.rs;
    o.f3 = i.f3;
    o.mw = do_st;
    for (int k = 0; k < 4; k++)
      o.be[k] = do_st && (k >= a) && (k < a + st_size);
    for (int k = 0; k < 4; k++) begin
      if (i.f3 == 3'd0) o.wd[k*8 +: 8] = i.wd[7:0];
      else if (i.f3 == 3'd1) o.wd[k*8 +: 8] = i.wd[(k%2)*8 +: 8];
      else o.wd[k*8 +: 8] = i.wd[k*8 +: 8];
    end
    o.mis = st_mis || ld_mis;
    o.fwd = (i.rs == 2'b10) ? i.pc : i.alu;
    return o;
  endfunction

  function automatic in_t mk_in(input logic v, input logic [31:0] alu, wd, pc,
                                input logic [4:0] rd, input logic rw, mw, mr,
                                input logic [1:0] rs, input logic [2:0] f3);
    in_t i;
    i.valid = v; i.alu = alu; i.flags = alu[3:0] ^ 4'hA; i.wd = wd; i.pc = pc;
    i.rd = rd; i.rw = rw; i.mw = mw; i.mr = mr; i.rs = rs; i.f3 = f3;
    return i;
  endfunction

  task automatic add(input string name, input logic r, st, fl, input in_t i,
                     input logic ev, erw, emw, emr, emis, input logic [3:0] ebe,
                     input logic [31:0] ealu, ewd, efwd);
    vec_t v;
    v.name = name; v.r = r; v.st = st; v.fl = fl; v.i = i;
    v.ev = ev; v.erw = erw; v.emw = emw; v.emr = emr; v.emis = emis;
    v.ebe = ebe; v.ealu = ealu; v.ewd = ewd; v.efwd = efwd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // driver: one cycle of stimulus, scoreboard update, sample #1 after the edge
  task automatic step(input in_t i, input logic r, st, fl, input string name);
    logic [W-1:0] e;
    reset = r; stall_m = st; flush_m = fl;
    valid_e = i.valid; aluresult_e = i.alu; flags_e = i.flags; writedata_e = i.wd;
    pcplus4_e = i.pc; rd_e = i.rd; regwrite_e = i.rw; memwrite_e = i.mw;
    memread_e = i.mr; resultsrc_e = i.rs; funct3_e = i.f3;
    if (r || fl) exp_state = '0;
    else if (!st) exp_state = model_load(i);
    exp_q.push_back(exp_state);
    @(posedge clk);
    #1;
    act.valid = valid_m; act.alu = aluresult_m; act.pc = pcplus4_m; act.flags = flags_m;
    act.rd = rd_m; act.rw = regwrite_m; act.mr = memread_m; act.rs = resultsrc_m;
    act.f3 = funct3_m; act.mw = memwrite_m; act.be = byteen_m; act.wd = wdata_m;
    act.mis = misalign_m; act.fwd = fwd_m;
    e = exp_q.pop_front();
    chk({name, " all outputs"}, 256'(act), 256'(e));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall_m = 1'b0; flush_m = 1'b0;
    valid_e = 1'b0; aluresult_e = '0; flags_e = '0; writedata_e = '0; pcplus4_e = '0;
    rd_e = '0; regwrite_e = 1'b0; memwrite_e = 1'b0; memread_e = 1'b0;
    resultsrc_e = '0; funct3_e = '0;

    add("reset1", 1, 0, 0, mk_in(1, 32'hCAFEF00D, 32'h12345678, 32'h200, 7, 1, 1, 0, 2, 2),
        0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0);
    add("reset2", 1, 0, 0, mk_in(1, 32'hCAFEF00D, 32'h12345678, 32'h200, 7, 1, 1, 0, 2, 2),
        0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0);
    add("sb", 0, 0, 0, mk_in(1, 32'h1003, 32'h123456AB, 32'h1007, 3, 0, 1, 0, 0, 0),
        1, 0, 1, 0, 0, 4'b1000, 32'h1003, 32'hABABABAB, 32'h1003);
    add("sw_mis", 0, 0, 0, mk_in(1, 32'h1002, 32'h123456AB, 32'h1006, 0, 0, 1, 0, 0, 2),
        1, 0, 0, 0, 1, 4'b0000, 32'h1002, 32'h123456AB, 32'h1002);
    add("lh_mis", 0, 0, 0, mk_in(1, 32'h1001, 32'h0, 32'h1005, 5, 1, 0, 1, 1, 1),
        1, 1, 0, 1, 1, 4'b0000, 32'h1001, 32'h0, 32'h1001);
    add("sh_hi", 0, 0, 0, mk_in(1, 32'h2002, 32'h0000BEEF, 32'h0, 0, 0, 1, 0, 0, 1),
        1, 0, 1, 0, 0, 4'b1100, 32'h2002, 32'hBEEFBEEF, 32'h2002);
    add("ld_beef", 0, 0, 0, mk_in(1, 32'hDEADBEEF, 32'h0, 32'h300, 9, 1, 0, 0, 0, 0),
        1, 1, 0, 0, 0, 4'b0000, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++)
      add($sformatf("stall%0d", k), 0, 1, 0,
          mk_in(1, 32'h11111111 + k, 32'hFFFF, 32'h40, 2, 0, 1, 1, 2, 1),
          1, 1, 0, 0, 0, 4'b0000, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    add("release", 0, 0, 0, mk_in(1, 32'h22222222, 32'h0, 32'h0, 4, 1, 0, 0, 0, 0),
        1, 1, 0, 0, 0, 4'b0000, 32'h22222222, 32'h0, 32'h22222222);
    add("stall_flush", 0, 1, 1, mk_in(1, 32'h33333333, 32'h0, 32'h0, 4, 1, 0, 0, 0, 0),
        0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0);
    add("fwd_pc", 0, 0, 0, mk_in(1, 32'h55, 32'h0, 32'h104, 1, 1, 0, 0, 2, 0),
        1, 1, 0, 0, 0, 4'b0000, 32'h55, 32'h0, 32'h104);
    add("fwd_alu", 0, 0, 0, mk_in(1, 32'h55, 32'h0, 32'h104, 1, 1, 0, 0, 0, 0),
        1, 1, 0, 0, 0, 4'b0000, 32'h55, 32'h0, 32'h55);
    add("stall_hold", 0, 1, 0, mk_in(1, 32'h77, 32'h0, 32'h108, 1, 1, 0, 0, 2, 0),
        1, 1, 0, 0, 0, 4'b0000, 32'h55, 32'h0, 32'h55);
    add("reset_in_stall", 1, 1, 0, mk_in(1, 32'h77, 32'h0, 32'h108, 1, 1, 0, 0, 2, 0),
        0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 32'h0);
    add("bubble_in", 0, 0, 0, mk_in(0, 32'h1000, 32'hA5, 32'h44, 2, 1, 1, 1, 0, 0),
        0, 0, 0, 0, 0, 4'b0000, 32'h1000, 32'hA5A5A5A5, 32'h1000);

    @(negedge clk);
    foreach (tbl[n]) begin
      step(tbl[n].i, tbl[n].r, tbl[n].st, tbl[n].fl, tbl[n].name);
      chk({tbl[n].name, " valid_m"},    256'(act.valid), 256'(tbl[n].ev));
      chk({tbl[n].name, " regwrite_m"}, 256'(act.rw),    256'(tbl[n].erw));
      chk({tbl[n].name, " memwrite_m"}, 256'(act.mw),    256'(tbl[n].emw));
      chk({tbl[n].name, " memread_m"},  256'(act.mr),    256'(tbl[n].emr));
      chk({tbl[n].name, " misalign_m"}, 256'(act.mis),   256'(tbl[n].emis));
      chk({tbl[n].name, " byteen_m"},   256'(act.be),    256'(tbl[n].ebe));
      chk({tbl[n].name, " aluresult_m"},256'(act.alu),   256'(tbl[n].ealu));
      chk({tbl[n].name, " wdata_m"},    256'(act.wd),    256'(tbl[n].ewd));
      chk({tbl[n].name, " fwd_m"},      256'(act.fwd),   256'(tbl[n].efwd));
    end

    for (int n = 0; n < 500; n++) begin
      in_t ri;
      logic rr, rst, rfl;
      ri.valid = ($urandom_range(0, 7) != 0);
      ri.alu = $urandom;
      ri.flags = 4'($urandom);
      ri.wd = $urandom;
      ri.pc = $urandom;
      ri.rd = 5'($urandom);
      ri.rw = 1'($urandom);
      ri.mw = 1'($urandom);
      ri.mr = 1'($urandom);
      ri.rs = 2'($urandom_range(0, 3));
      ri.f3 = 3'($urandom_range(0, 7));
      rr  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 3) == 0);
      rfl = ($urandom_range(0, 9) == 0);
      step(ri, rr, rst, rfl, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
